// File: rtl/pulse_event_sched_if.sv
// Event channel between the pulse scheduler and its downstream consumer.
// The scheduler offers an event id with valid; the consumer accepts with ready.
interface pulse_event_sched_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid_O;
    logic [ID_W-1:0] evt_id_O;
    logic            evt_ready_I;

    modport master (
        output evt_valid_O,
        output evt_id_O,
        input  evt_ready_I
    );

    modport slave (
        input  evt_valid_O,
        input  evt_id_O,
        output evt_ready_I
    );
endinterface

// File: rtl/pulse_event_sched.sv
// Round-robin scheduler for single-cycle event pulses.
// Each source latches a pending request. Pending requests are serialised onto one
// valid/ready event channel. A pulse on a source that is already pending (and not
// being granted in that cycle) is dropped. Drops are recorded in a sticky
// per-source flag and in a saturating total counter.
module pulse_event_sched #(
    parameter int NUM   = 3,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM-1:0]             pulse_I,
    pulse_event_sched_if.master        evt,
    input  logic                       clr_I,
    output logic [NUM-1:0]             overflow_O,
    output logic [CNT_W-1:0]           drop_cnt_O
);
    localparam int PC_W  = $clog2(NUM + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};
    localparam logic [ID_W:0]    NUM_X   = (ID_W + 1)'(NUM);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t            state_reg, state_next;
    logic [NUM-1:0]    pending_reg, pending_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic              valid_reg, valid_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [NUM-1:0]    overflow_reg, overflow_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

    logic              hs;
    logic [NUM-1:0]    gnt;
    logic [NUM-1:0]    avail;
    logic [NUM-1:0]    drop;
    logic [NUM-1:0]    rot;
    logic [ID_W-1:0]   sel_off;
    logic [ID_W:0]     sel_sum;
    logic [ID_W-1:0]   sel_id;
    logic [PC_W-1:0]   drop_pc;
    logic [SUM_W-1:0]  cnt_sum;

    assign hs = valid_reg & evt.evt_ready_I;

    // Per-source grant, remaining request and drop detection.
    // A pulse on the source being granted this cycle simply re-arms it.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_src
            assign gnt[gi]   = hs & (id_reg == ID_W'(gi));
            assign avail[gi] = pending_reg[gi] & ~gnt[gi];
            assign drop[gi]  = pulse_I[gi] & avail[gi];
        end
    endgenerate

    assign pending_next = avail | pulse_I;

    // Rotate the remaining requests so that bit 0 corresponds to ptr.
    assign rot = NUM'({avail, avail} >> ptr_reg);

    // Pick the first remaining request at or after ptr (cyclic), using the
    // pointer value held this cycle; same-cycle pulses are not candidates.
    always_comb begin
        sel_off = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel_off = ID_W'(k);
            end
        end
        sel_sum = {1'b0, ptr_reg} + {1'b0, sel_off};
        if (sel_sum >= NUM_X) begin
            sel_sum = sel_sum - NUM_X;
        end
        sel_id = sel_sum[ID_W-1:0];
    end

    // Channel FSM: offer from IDLE, chain back-to-back offers on handshake.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        id_next    = id_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|avail) begin
                    state_next = OFFER;
                    valid_next = 1'b1;
                    id_next    = sel_id;
                end
            end
            OFFER: begin
                if (hs) begin
                    ptr_next = (id_reg == LAST_ID) ? '0 : id_reg + ID_W'(1);
                    if (|avail) begin
                        id_next = sel_id;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // Drop status: clear first, then apply this cycle's drops; counter saturates.
    always_comb begin
        drop_pc = '0;
        for (int i = 0; i < NUM; i++) begin
            drop_pc = drop_pc + PC_W'(drop[i]);
        end
        cnt_sum       = (clr_I ? '0 : SUM_W'(drop_cnt_reg)) + SUM_W'(drop_pc);
        drop_cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        overflow_next = (clr_I ? '0 : overflow_reg) | drop;
    end

    // State and output registers; reset discards all pending and offered events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            ptr_reg      <= '0;
            valid_reg    <= 1'b0;
            id_reg       <= '0;
            overflow_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            ptr_reg      <= ptr_next;
            valid_reg    <= valid_next;
            id_reg       <= id_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign evt.evt_valid_O = valid_reg;
    assign evt.evt_id_O    = id_reg;
    assign overflow_O      = overflow_reg;
    assign drop_cnt_O      = drop_cnt_reg;
endmodule

// File: doc/pulse_event_sched.md
# pulse_event_sched

Round-robin scheduler for single-cycle event pulses in the HDMI output core. It latches up to NUM independent pulse events, such as the posedge/negedge outputs of `pulse_gen` (sync edges, frame-start, buffer-swap requests), as pending requests. It then serialises them onto one valid/ready event channel for the shared downstream consumer. Events that arrive while the same source is still pending are dropped and recorded.

## Interface
- `NUM`, 3, number of pulse sources (2..16)
- `ID_W`, 2, width of the event id; must satisfy 2^ID_W >= NUM
- `CNT_W`, 8, width of the drop counter

- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pulse_I`  in  NUM  event pulses, one bit per source, synchronous to `clk`
- `evt_valid_O`  out  1  event offered on channel
- `evt_id_O`  out  ID_W  index of source being offered
- `evt_ready_I`  in  1  consumer accepts the offered event
- `clr_I`  in  1  synchronous clear of overflow/drop status
- `overflow_O`  out  NUM  sticky per-source drop flag
- `drop_cnt_O`  out  CNT_W  saturating total of dropped events

## Operation
- State: `pending[NUM]`, round-robin pointer `ptr` (0..NUM-1), FSM {IDLE, OFFER}, registered `evt_valid_O`/`evt_id_O`, status registers.
- Handshake `hs = evt_valid_O & evt_ready_I`. `gnt` = one-hot of `evt_id_O` when `hs`, else 0.
- Pending update per source i: `pending[i] <= (pending[i] & ~gnt[i]) | pulse_I[i]`.
  - A pulse in the same cycle its own pending bit is granted re-sets the bit. This is not a drop.
- Drop per source i: `pulse_I[i] & pending[i] & ~gnt[i]`.
- Selection: first set bit of `pending & ~gnt`, searching cyclically from `ptr` upward with wrap NUM-1 -> 0. Same-cycle `pulse_I` does not take part in selection.
- IDLE:
  - If any pending, load the selection into `evt_id_O`, set `evt_valid_O`, go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - `evt_valid_O` and `evt_id_O` stay stable while `!evt_ready_I`. There is no timeout.
  - On `hs`, set `ptr <= (evt_id_O+1) mod NUM`.
  - On `hs`, if `pending & ~gnt` is nonzero, load the next selection immediately, so back-to-back events carry no bubble. Otherwise clear `evt_valid_O` and go to IDLE.
- Status:
  - `overflow_O[i]` is set by a drop on source i.
  - `drop_cnt_O` is incremented by the popcount of the drop vector and saturates at 2^CNT_W-1.
  - With `clr_I`, both are first cleared, then the same cycle's drops are applied. Net result: `overflow_O` equals the drop vector and `drop_cnt_O` equals the popcount.
- Reset (async): `pending`=0, `ptr`=0, IDLE, `evt_valid_O`=0, `evt_id_O`=0, `overflow_O`=0, `drop_cnt_O`=0. Reset mid-offer discards all pending and offered events.

## Timing
- A pulse sampled at edge k sets `pending` at edge k and drives `evt_valid_O` high after edge k+1, so latency is 2 cycles from an idle channel.
- Throughput is one event per cycle while `evt_ready_I` stays high and events are pending.
- `evt_ready_I` may be high while `evt_valid_O` is low; this has no effect.
- All outputs are registered. There is no combinational path from inputs to outputs.
- A source pulsing every cycle while held back by `!evt_ready_I` drops one event per cycle after the first.

## Test plan
- **Single event:**
  - Stimulus: NUM=3; `pulse_I`=3'b010 for one cycle at edge k, `evt_ready_I`=1.
  - Required: `evt_valid_O`=1, `evt_id_O`=1 after edge k+1, low after edge k+2; `ptr`=2; no drops.
- **Simultaneous events and round-robin:**
  - Stimulus: `pulse_I`=3'b111 in one cycle, `evt_ready_I`=1.
  - Required: ids 0,1,2 on consecutive cycles with no bubble. Repeat with `ptr`=2 gives order 2,0,1.
- **Backpressure hold:**
  - Stimulus: `pulse_I`=3'b001, `evt_ready_I`=0 for 5 cycles.
  - Required: `evt_valid_O`=1 and `evt_id_O`=0 constant; accepted on the first ready cycle.
- **Drop and saturation:**
  - Stimulus: `evt_ready_I`=0; pulse source 2 in 4 separate cycles.
  - Required: `overflow_O`=3'b100, `drop_cnt_O`=3. With CNT_W=2 and 5 drops, the counter holds 3.
- **Grant/pulse collision and clear:**
  - Stimulus: pulse source 0 in the same cycle its event is accepted.
  - Required: no drop; id 0 is offered again.
  - Stimulus: `clr_I` coinciding with a drop on source 1.
  - Required: `overflow_O`=3'b010, `drop_cnt_O`=1.
- **Async reset mid-offer:**
  - Stimulus: assert `rst` between edges while `evt_valid_O`=1 with 2 sources pending.
  - Required: all outputs 0 immediately. After release, no event is offered until a new pulse arrives.
